// File: rtl/counter_defs.sv
// ---------------------------------------------------------------------------
// counter_defs
// Shared encodings for the counter family. The direction and boundary
// controls are plain 1-bit inputs, so these constants name their levels
// rather than defining enum types.
//   MODE_UP / MODE_DOWN : levels of the direction input
//   SAT_ON  / SAT_WRAP  : levels of the boundary-behaviour input
//   COUNTER_MAX_WIDTH   : widest counter any variant supports
// ---------------------------------------------------------------------------
package counter_defs;

   localparam logic MODE_UP   = 1'b1;
   localparam logic MODE_DOWN = 1'b0;
   localparam logic SAT_ON    = 1'b1;
   localparam logic SAT_WRAP  = 1'b0;

   localparam int COUNTER_MAX_WIDTH = 16;

endpackage : counter_defs

// File: rtl/updown_next.sv
// ---------------------------------------------------------------------------
// updown_next
// Combinational next-state function of a modulo-(MAX+1) up/down counter.
// It computes the value the counter takes if it steps. Hold, load and preset
// are decided by the caller.
//   count_i      : current count
//   mode_i       : direction (MODE_UP / MODE_DOWN)
//   sat_i        : boundary behaviour (SAT_ON / SAT_WRAP)
//   next_count_o : count after one step
//   wrap_evt_o   : the step crosses the MAX<->0 boundary
// ---------------------------------------------------------------------------
module updown_next
   import counter_defs::*;
#(
   parameter int WIDTH = 4,
   parameter int MAX   = 9
) (
   input  logic [WIDTH-1:0] count_i,
   input  logic             mode_i,
   input  logic             sat_i,
   output logic [WIDTH-1:0] next_count_o,
   output logic             wrap_evt_o
);

   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ZERO_V = '0;
   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

   always_comb begin
      next_count_o = count_i;
      wrap_evt_o   = 1'b0;
      if (mode_i == MODE_UP) begin
         // ">=" rather than "==" so that an out-of-range value can never
         // step further away from the legal range.
         if (count_i >= MAX_V) begin
            if (sat_i == SAT_WRAP) begin
               next_count_o = ZERO_V;
               wrap_evt_o   = 1'b1;
            end else begin
               next_count_o = MAX_V;
            end
         end else begin
            next_count_o = count_i + ONE_V;
         end
      end else begin
         if (count_i == ZERO_V) begin
            if (sat_i == SAT_WRAP) begin
               next_count_o = MAX_V;
               wrap_evt_o   = 1'b1;
            end else begin
               next_count_o = ZERO_V;
            end
         end else if (count_i > MAX_V) begin
            next_count_o = MAX_V;
         end else begin
            next_count_o = count_i - ONE_V;
         end
      end
   end

endmodule : updown_next

// File: rtl/updown_counter_param.sv
// ---------------------------------------------------------------------------
// updown_counter_param
// Parametrised up/down counter with asynchronous clear, synchronous preset
// and clamped load, wrap or saturate at the boundaries, and a combinational
// terminal count for cascading stages.
// Parameters:
//   WIDTH       : counter width, 1..16
//   MAX         : terminal count, 1..2^WIDTH-1
//   RESET_VALUE : value forced by clear, 0..MAX
// Ports:
//   clk    : rising-edge clock
//   clear  : asynchronous active-high clear (count=RESET_VALUE, wrap=0)
//   enable : count enable / cascade input from the lower stage's tc
//   mode   : 1 = up, 0 = down
//   sat    : 1 = saturate, 0 = wrap
//   preset : synchronous load of MAX (beats load)
//   load   : synchronous load of din, clamped to MAX
//   din    : load value
//   count  : registered count
//   tc     : combinational terminal count
//   wrap   : registered one-cycle rollover pulse
// ---------------------------------------------------------------------------
module updown_counter_param
   import counter_defs::*;
#(
   parameter int WIDTH       = 4,
   parameter int MAX         = 9,
   parameter int RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             enable,
   input  logic             mode,
   input  logic             sat,
   input  logic             preset,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   // Reject illegal parameter combinations at elaboration.
   if ((WIDTH < 1) || (WIDTH > COUNTER_MAX_WIDTH) ||
       (MAX < 1) || (MAX > ((1 << WIDTH) - 1)) ||
       (RESET_VALUE < 0) || (RESET_VALUE > MAX)) begin : g_param_error
      $error("updown_counter_param: illegal WIDTH/MAX/RESET_VALUE combination");
   end

   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] ZERO_V  = '0;

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q,  wrap_d;
   logic [WIDTH-1:0] step_count;
   logic             step_wrap;

   updown_next #(
      .WIDTH (WIDTH),
      .MAX   (MAX)
   ) u_next (
      .count_i      (count_q),
      .mode_i       (mode),
      .sat_i        (sat),
      .next_count_o (step_count),
      .wrap_evt_o   (step_wrap)
   );

   // Load/preset mux. Only an enabled step can raise the wrap pulse.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (preset) begin
         count_d = MAX_V;
      end else if (load) begin
         count_d = (din > MAX_V) ? MAX_V : din;
      end else if (enable) begin
         count_d = step_count;
         wrap_d  = step_wrap;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         count_q <= RESET_V;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   // tc looks only at enable, direction and count so that a chain of stages
   // ripples combinationally within one cycle.
   assign tc = enable & (((mode == MODE_UP)   && (count_q == MAX_V)) ||
                         ((mode == MODE_DOWN) && (count_q == ZERO_V)));

   assign count = count_q;
   assign wrap  = wrap_q;

endmodule : updown_counter_param

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised synchronous up/down counter: the generalised successor of the fixed 3-bit JK counter used in the cruise-control datapath. It adds arbitrary width and modulus, synchronous load and preset, selectable wrap or saturate behaviour, and a cascade terminal-count output. Instances serve as speed digits, set-point registers and interval timers, and can be chained into multi-digit counters.

## Interface
- WIDTH, 4: counter width in bits; valid range 1..16.
- MAX, 9: terminal count, the highest value the counter reaches; 1 <= MAX <= 2^WIDTH-1.
- RESET_VALUE, 0: value forced by clear; must be <= MAX.
- clk  in  1  rising-edge clock (single clock domain).
- clear  in  1  asynchronous, active-high reset; forces count to RESET_VALUE.
- enable  in  1  count enable; also the cascade input from the lower stage's tc.
- mode  in  1  direction: 1 = up, 0 = down.
- sat  in  1  boundary behaviour: 1 = saturate, 0 = wrap.
- preset  in  1  synchronous load of MAX.
- load  in  1  synchronous load of din.
- din  in  WIDTH  load value.
- count  out  WIDTH  current count, registered.
- tc  out  1  combinational terminal count, for cascading.
- wrap  out  1  registered one-cycle pulse on rollover.

## Operation
- Per-edge priority: clear (async) > preset > load > enable count > hold.
- preset: count <= MAX. It ignores enable.
- load: count <= din if din <= MAX, else MAX (clamped). It ignores enable.
- Count, when enable=1 and no load or preset:
  - mode=1, count<MAX: count+1.
  - mode=1, count==MAX: 0 if sat=0, else hold MAX.
  - mode=0, count>0: count-1.
  - mode=0, count==0: MAX if sat=0, else hold 0.
- Arithmetic is unsigned, modulo MAX+1. count never exceeds MAX under any input sequence.
- tc = enable & ((mode & count==MAX) | (~mode & count==0)). tc is independent of sat, load and preset. Chain stages by wiring a stage's tc into the next stage's enable.
- wrap is 1 for exactly the cycle after an edge on which a wrap transition (MAX->0 or 0->MAX) occurred. It is 0 for saturate holds, loads and presets.
- mode and sat may change on any cycle. They take effect at the next edge and need no flush.

## Timing
- Reset values: count=RESET_VALUE, wrap=0. tc follows from inputs.
- clear asserted: outputs take reset values immediately, asynchronously, with no clock required.
- clear deasserted: the first edge with clear low acts normally; there are no dead cycles.
- Latency: the count update is visible 1 clk after the sampling edge. tc is combinational, valid in the same cycle. wrap is asserted in the cycle following the rollover edge, together with the new count.
- load and preset together: preset wins.
- enable with load: load wins and the count step is discarded.
- clear during a load or preset cycle: clear wins, and the load is lost.
- Degenerate MAX=1: the counter toggles 0/1. Wrap and tc still behave as above.

## Structure
- Shared package/header `counter_defs`: MODE_UP=1, MODE_DOWN=0, SAT_ON=1, SAT_WRAP=0. Future counter variants reuse it.
- One combinational sub-module, `updown_next`. It takes count, mode, sat and MAX, and returns next_count and wrap_evt.
- The top level holds the async-clear register, the load/preset mux, and the tc logic.
- Parameter legality (MAX, RESET_VALUE vs WIDTH) is checked at elaboration.

## Test plan
- Reset: assert clear mid-count at count=6 without a clock edge -> count=0 immediately, wrap=0. Deassert clear -> the next edge with enable=1, mode=1 gives count=1.
- Up-wrap: WIDTH=4, MAX=9, sat=0, mode=1, 12 enabled edges from 0. The count runs 1..9, 0, 1, 2. tc=1 only while count=9. wrap=1 only in the cycle count became 0.
- Down-saturate: sat=1, mode=0, start 2, 4 enabled edges -> count 1, 0, 0, 0. wrap stays 0. tc=1 while count=0.
- Load/preset priority: din=13 with load=1 -> count=9 (clamped). din=4 with load=1 and enable=1 -> count=4. load=1 and preset=1 -> count=9.
- Direction change at boundary: count=0, mode switches 1->0 with sat=0 -> next count 9, wrap=1. Switch back to mode=1 -> next count 0, wrap=1.
- Cascade: two instances, with the low tc driving the high enable, both MAX=9, 100 edges up from 00. The pair reads 99, then 00. The high stage pulses wrap once.
